// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: shared definitions for the mips_32 boot-time program loader.
//   - ld_state_t : loader FSM states
//   - HDR_BYTES, WORD_BYTES : stream framing sizes
//   - OPC_HLT : mips_32 halt opcode, used when checking loaded images
//   - xor_fold() : running-checksum update helper
package mips_loader_pkg;

   typedef enum logic [2:0] {
      CNT_HI = 3'd0,
      CNT_LO = 3'd1,
      WORD   = 3'd2,
      CHK    = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } ld_state_t;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   localparam logic [5:0] OPC_HLT = 6'h3F;

   // Fold one stream byte into the running XOR checksum.
   function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/loader_word_pack.sv
// loader_word_pack: 8->32 big-endian word assembler.
// Ports:
//   clk1       in   clock
//   rst        in   synchronous active-high reset
//   clr        in   synchronous clear of the partial word (new load starting)
//   byte_en    in   byte_in is accepted this cycle
//   byte_in    in   8-bit stream byte, MSB of the word arrives first
//   word       out  assembled word; valid only while word_valid is high
//   word_valid out  high on the cycle the 4th byte of a word is accepted
// word/word_valid are combinational on the accepting cycle so the parent can
// register the memory write one cycle after the last byte.
module loader_word_pack
   import mips_loader_pkg::*;
(
   input  logic        clk1,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   logic [23:0] shift_r;
   logic [1:0]  idx_r;

   // Shift register and byte index; the index wraps 3 -> 0 on its own.
   always_ff @(posedge clk1) begin
      if (rst || clr) begin
         shift_r <= 24'd0;
         idx_r   <= 2'd0;
      end else if (byte_en) begin
         shift_r <= {shift_r[15:0], byte_in};
         idx_r   <= idx_r + 2'd1;
      end else begin
         shift_r <= shift_r;
         idx_r   <= idx_r;
      end
   end

   assign word       = {shift_r, byte_in};
   assign word_valid = byte_en && (idx_r == LAST_IDX);

endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: boot-time program loader for the mips_32 core.
// Receives [count_hi, count_lo, N x 4-byte big-endian words, xor checksum],
// writes word k to memory address BASE+k, then releases the core.
// Ports:
//   clk1      in   core phase-1 clock
//   rst       in   synchronous active-high reset
//   in_valid  in   in_data valid
//   in_data   in   stream byte
//   in_ready  out  loader accepts a byte this cycle
//   clear     in   restart from DONE/ERR
//   mem_we    out  one-cycle memory write strobe
//   mem_addr  out  word address
//   mem_wdata out  instruction word
//   cpu_run   out  core may fetch (DONE only)
//   done      out  load completed with good checksum
//   error     out  checksum mismatch or length overflow
module mips_prog_loader
   import mips_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int BASE   = 0
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              clear,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_run,
   output logic              done,
   output logic              error
);

   // Largest word count that fits between BASE and the top of memory.
   localparam logic [16:0]       LIMIT     = 17'((1 << ADDR_W) - BASE);
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

   ld_state_t         state_r;
   logic [7:0]        cnt_hi_r;
   logic [15:0]       n_r;
   logic [15:0]       wcnt_r;
   logic [7:0]        chk_r;
   logic [ADDR_W-1:0] waddr_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [31:0]       mem_wdata_r;
   logic              done_r;
   logic              error_r;
   logic              cpu_run_r;

   logic              accept_s;
   logic              pack_en_s;
   logic              restart_s;
   logic [15:0]       n_full_s;
   logic [15:0]       wcnt_next_s;
   logic [31:0]       word_s;
   logic              word_valid_s;

   assign in_ready    = (state_r == CNT_HI) || (state_r == CNT_LO) ||
                        (state_r == WORD)   || (state_r == CHK);
   assign accept_s    = in_valid && in_ready;
   assign pack_en_s   = accept_s && (state_r == WORD);
   assign restart_s   = clear && ((state_r == DONE) || (state_r == ERR));
   assign n_full_s    = {cnt_hi_r, in_data};
   assign wcnt_next_s = wcnt_r + 16'd1;

   loader_word_pack u_pack (
      .clk1       (clk1),
      .rst        (rst),
      .clr        (restart_s),
      .byte_en    (pack_en_s),
      .byte_in    (in_data),
      .word       (word_s),
      .word_valid (word_valid_s)
   );

   // Loader FSM with counters, checksum and registered memory/status outputs.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_r     <= CNT_HI;
         cnt_hi_r    <= 8'd0;
         n_r         <= 16'd0;
         wcnt_r      <= 16'd0;
         chk_r       <= 8'd0;
         waddr_r     <= BASE_ADDR;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'd0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         cpu_run_r   <= 1'b0;
      end else begin
         mem_we_r <= 1'b0;
         case (state_r)
            CNT_HI: begin
               if (accept_s) begin
                  cnt_hi_r <= in_data;
                  chk_r    <= xor_fold(chk_r, in_data);
                  state_r  <= CNT_LO;
               end
            end
            CNT_LO: begin
               if (accept_s) begin
                  n_r   <= n_full_s;
                  chk_r <= xor_fold(chk_r, in_data);
                  if ({1'b0, n_full_s} > LIMIT) begin
                     state_r <= ERR;
                     error_r <= 1'b1;
                  end else if (n_full_s == 16'd0) begin
                     state_r <= CHK;
                  end else begin
                     state_r <= WORD;
                  end
               end
            end
            WORD: begin
               if (accept_s) begin
                  chk_r <= xor_fold(chk_r, in_data);
                  if (word_valid_s) begin
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= waddr_r;
                     mem_wdata_r <= word_s;
                     waddr_r     <= waddr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                     wcnt_r      <= wcnt_next_s;
                     if (wcnt_next_s == n_r) begin
                        state_r <= CHK;
                     end
                  end
               end
            end
            CHK: begin
               // chk_r already holds the XOR of every preceding byte.
               if (accept_s) begin
                  if (in_data == chk_r) begin
                     state_r   <= DONE;
                     done_r    <= 1'b1;
                     cpu_run_r <= 1'b1;
                  end else begin
                     state_r <= ERR;
                     error_r <= 1'b1;
                  end
               end
            end
            DONE, ERR: begin
               if (clear) begin
                  state_r   <= CNT_HI;
                  done_r    <= 1'b0;
                  error_r   <= 1'b0;
                  cpu_run_r <= 1'b0;
                  chk_r     <= 8'd0;
                  wcnt_r    <= 16'd0;
                  waddr_r   <= BASE_ADDR;
               end
            end
            default: begin
               state_r   <= CNT_HI;
               done_r    <= 1'b0;
               error_r   <= 1'b0;
               cpu_run_r <= 1'b0;
               chk_r     <= 8'd0;
               wcnt_r    <= 16'd0;
               waddr_r   <= BASE_ADDR;
            end
         endcase
      end
   end

   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign done      = done_r;
   assign error     = error_r;
   assign cpu_run   = cpu_run_r;

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: directed self-checking bench for mips_prog_loader.
// The bench builds each byte stream and the list of writes it must produce
// from a word list; a negedge monitor checks every memory write against it.
module tb_mips_prog_loader;
   import mips_loader_pkg::*;

   localparam int AW = 10;
   localparam int BS = 0;

   logic          clk1 = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          clear;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_run;
   logic          done;
   logic          error;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   logic [31:0]   wq[$];   // words of the current program
   logic [7:0]    sq[$];   // bytes of the current stream
   logic [AW-1:0] ea[$];   // expected write addresses
   logic [31:0]   ed[$];   // expected write data

   mips_prog_loader #(.ADDR_W(AW), .BASE(BS)) dut (
      .clk1      (clk1),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .clear     (clear),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_run   (cpu_run),
      .done      (done),
      .error     (error)
   );

   always #5 clk1 = ~clk1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Write checker: every mem_we pulse must match the next expected write.
   always @(negedge clk1) begin
      if (mon_en) begin
         check("cpu_run_eq_done", 32'(cpu_run), 32'(done));
         if (mem_we !== 1'b0) begin
            if (ea.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                        mem_addr, mem_wdata);
            end else begin
               check("wr_addr", 32'(mem_addr), 32'(ea.pop_front()));
               check("wr_data", mem_wdata, ed.pop_front());
            end
         end
      end
   end

   // Build stream + expected writes from wq; delta corrupts the checksum.
   task automatic build(input logic [7:0] delta);
      logic [15:0] n;
      logic [7:0]  x;
      logic [31:0] w;
      n = 16'(wq.size());
      sq.delete();
      sq.push_back(n[15:8]);
      sq.push_back(n[7:0]);
      for (int k = 0; k < wq.size(); k++) begin
         w = wq[k];
         sq.push_back(w[31:24]);
         sq.push_back(w[23:16]);
         sq.push_back(w[15:8]);
         sq.push_back(w[7:0]);
         ea.push_back(AW'(BS + k));
         ed.push_back(w);
      end
      x = 8'd0;
      for (int i = 0; i < sq.size(); i++) x = x ^ sq[i];
      sq.push_back(x ^ delta);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      if (gap) begin
         in_valid = 1'b0;
         @(posedge clk1); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      check("in_ready_when_sending", 32'(in_ready), 32'd1);
      @(posedge clk1); #1;
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic run_stream(input bit gap, input bit ok);
      for (int i = 0; i < sq.size(); i++) begin
         if (i == sq.size() - 1) check("status_before_chk", 32'({done, error}), 32'd0);
         send_byte(sq[i], gap);
      end
      check("done",     32'(done),     32'(ok));
      check("cpu_run",  32'(cpu_run),  32'(ok));
      check("error",    32'(error),    32'(!ok));
      check("in_ready_final", 32'(in_ready), 32'd0);
      check("writes_pending", 32'(ea.size()), 32'd0);
   endtask

   // Clear with a junk byte offered; it must not be taken.
   task automatic do_clear();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      clear    = 1'b1;
      @(posedge clk1); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      check("clear_in_ready", 32'(in_ready), 32'd1);
      check("clear_status",   32'({done, error, cpu_run}), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk1); #1;
      @(posedge clk1); #1;
      rst = 1'b0;
      check("rst_mem", 32'({mem_we, 22'd0, mem_addr}), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_status", 32'({done, error, cpu_run}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic load_single();
      wq.delete();
      wq.push_back(32'h28010009);
      build(8'h00);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clear    = 1'b0;
      @(posedge clk1); #1;
      mon_en = 1'b1;
      do_reset();

      // Single word; pin the model against the hand-written stream.
      load_single();
      check("pin_len", 32'(sq.size()), 32'd7);
      check("pin_b2", 32'(sq[2]), 32'h28);
      check("pin_chk", 32'(sq[6]), 32'h21);
      check("pin_exp_addr", 32'(ea[0]), 32'd0);
      run_stream(1'b0, 1'b1);
      do_clear();

      // Eleven-word program with a gap before every byte.
      wq.delete();
      wq.push_back(32'h2801000A); wq.push_back(32'h28020014);
      wq.push_back(32'h0C000006); wq.push_back(32'h00221800);
      wq.push_back(32'h2863FFFF); wq.push_back(32'h14600002);
      wq.push_back(32'h00432020); wq.push_back(32'hAC040010);
      wq.push_back(32'h8C050010); wq.push_back(32'h03E00008);
      wq.push_back({OPC_HLT, 26'd0});
      build(8'h00);
      check("pin_eleven_len", 32'(sq.size()), 32'd47);
      check("pin_hlt", ed[10], 32'hFC000000);
      run_stream(1'b1, 1'b1);
      do_clear();

      // Bad checksum: write still lands, then error.
      wq.delete();
      wq.push_back(32'h28010009);
      build(8'h01);
      check("pin_bad_chk", 32'(sq[6]), 32'h20);
      run_stream(1'b0, 1'b0);
      do_clear();
      load_single();
      run_stream(1'b0, 1'b1);
      do_clear();

      // Overflow: N = 1025.
      send_byte(8'h04, 1'b0);
      send_byte(8'h01, 1'b0);
      check("ovf_error", 32'(error), 32'd1);
      check("ovf_in_ready", 32'(in_ready), 32'd0);
      check("ovf_done", 32'(done), 32'd0);
      in_valid = 1'b1;
      repeat (3) begin @(posedge clk1); #1; end
      in_valid = 1'b0;
      check("ovf_stays_err", 32'({error, in_ready}), 32'b10);
      do_clear();

      // N = 1024 exactly fits: no error, still accepting payload.
      send_byte(8'h04, 1'b0);
      send_byte(8'h00, 1'b0);
      check("fit_error", 32'(error), 32'd0);
      check("fit_in_ready", 32'(in_ready), 32'd1);
      do_reset();

      // Zero length.
      wq.delete();
      build(8'h00);
      check("pin_zero", 32'(sq[2]), 32'h00);
      run_stream(1'b0, 1'b1);
      do_clear();

      // Reset after 2 of 4 payload bytes: nothing written.
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      do_reset();
      repeat (3) begin @(posedge clk1); #1; end
      load_single();
      run_stream(1'b1, 1'b1);

      repeat (2) begin @(posedge clk1); #1; end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
